// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Combinational next-PC lookup for fetch, trained from MEM with resolved outcomes.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  output logic              mispredict,
  input  logic              flush,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;
  logic             unused_pc_bits;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];
  assign unused_pc_bits = ^upd_pc[1:0];

  // Lookup sees pre-update contents; outputs are forced to fall-through while in reset.
  always_comb begin
    pred_hit    = !RST && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ctr_q[lk_idx][CTR_W-1];
    pred_target = pred_taken ? tgt_q[lk_idx] : lookup_pc + 32'd4;
  end

  assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign mispredict = upd_en && ((upd_taken != upd_pred_taken) ||
                                 (upd_taken && (upd_target != upd_pred_target)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q          <= '0;
      tag_q            <= '{default: '0};
      tgt_q            <= '{default: '0};
      ctr_q            <= '{default: '0};
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      // Counters observe every accepted update, even one cancelled by flush.
      if (upd_en) begin
        if (!(&perf_branches))
          perf_branches <= perf_branches + PERF_W'(1);
        if (mispredict && !(&perf_mispredicts))
          perf_mispredicts <= perf_mispredicts + PERF_W'(1);
      end

      if (flush) begin
        valid_q <= '0;
      end else if (upd_en) begin
        if (up_hit) begin
          if (upd_taken) begin
            if (!(&ctr_q[up_idx]))
              ctr_q[up_idx] <= ctr_q[up_idx] + CTR_W'(1);
            tgt_q[up_idx] <= upd_target;
          end else if (|ctr_q[up_idx]) begin
            ctr_q[up_idx] <= ctr_q[up_idx] - CTR_W'(1);
          end
        end else if (upd_taken) begin
          valid_q[up_idx] <= 1'b1;
          tag_q[up_idx]   <= up_tag;
          tgt_q[up_idx]   <= upd_target;
          ctr_q[up_idx]   <= CTR_INIT;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, perf saturation
// sequence, and randomized traffic against an abstract per-PC reference model.
module tb_branch_predictor;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic        CLK;
  logic        rst, upd_en, upd_taken, upd_pred_taken, flush;
  logic [31:0] lookup_pc, upd_pc, upd_target, upd_pred_target;

  logic        a_hit, a_tk, a_mp;
  logic [31:0] a_tg;
  logic [31:0] a_pb, a_pm;
  logic        b_hit, b_tk, b_mp;
  logic [31:0] b_tg;
  logic [3:0]  b_pb, b_pm;

  branch_predictor #(.ENTRIES(16), .CTR_W(2), .PERF_W(32)) dut (
    .CLK(CLK), .RST(rst), .lookup_pc(lookup_pc),
    .pred_hit(a_hit), .pred_taken(a_tk), .pred_target(a_tg),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(a_mp), .flush(flush),
    .perf_branches(a_pb), .perf_mispredicts(a_pm)
  );

  branch_predictor #(.ENTRIES(4), .CTR_W(1), .PERF_W(4)) dut_small (
    .CLK(CLK), .RST(rst), .lookup_pc(lookup_pc),
    .pred_hit(b_hit), .pred_taken(b_tk), .pred_target(b_tg),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(b_mp), .flush(flush),
    .perf_branches(b_pb), .perf_mispredicts(b_pm)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each slot remembers the full word address (pc>>2) it holds,
  // a numeric confidence 0..CMAX, and a target. Config 0 = dut, config 1 = dut_small.
  int unsigned     NE   [2] = '{16, 4};
  int unsigned     CMAX [2] = '{3, 1};
  longint unsigned PMAX [2] = '{64'hFFFF_FFFF, 64'd15};
  bit              m_valid[2][16];
  int unsigned     m_line [2][16];
  bit [31:0]       m_tgt  [2][16];
  int unsigned     m_ctr  [2][16];
  longint unsigned m_pb[2], m_pm[2];

  function automatic bit exp_misp();
    if (!upd_en) return 1'b0;
    if (upd_taken != upd_pred_taken) return 1'b1;
    return upd_taken && (upd_target != upd_pred_target);
  endfunction

  function automatic void mpred(input int c, input bit [31:0] pc,
                                output bit hit, output bit tk, output bit [31:0] tg);
    int unsigned i = (pc >> 2) % NE[c];
    hit = !rst && m_valid[c][i] && (m_line[c][i] == (pc >> 2));
    tk  = hit && (m_ctr[c][i] > CMAX[c] / 2);
    tg  = tk ? m_tgt[c][i] : pc + 32'd4;
  endfunction

  function automatic void mupdate(input int c);
    int unsigned i;
    bit hit;
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[c][k] = 1'b0; m_line[c][k] = 0; m_tgt[c][k] = '0; m_ctr[c][k] = 0;
      end
      m_pb[c] = 0; m_pm[c] = 0;
      return;
    end
    if (upd_en) begin
      if (m_pb[c] < PMAX[c]) m_pb[c]++;
      if (exp_misp() && m_pm[c] < PMAX[c]) m_pm[c]++;
    end
    if (flush) begin
      for (int k = 0; k < 16; k++) m_valid[c][k] = 1'b0;
      return;
    end
    if (!upd_en) return;
    i   = (upd_pc >> 2) % NE[c];
    hit = m_valid[c][i] && (m_line[c][i] == (upd_pc >> 2));
    if (hit) begin
      if (upd_taken) begin
        if (m_ctr[c][i] < CMAX[c]) m_ctr[c][i]++;
        m_tgt[c][i] = upd_target;
      end else if (m_ctr[c][i] > 0) begin
        m_ctr[c][i]--;
      end
    end else if (upd_taken) begin
      m_valid[c][i] = 1'b1;
      m_line[c][i]  = upd_pc >> 2;
      m_tgt[c][i]   = upd_target;
      m_ctr[c][i]   = CMAX[c] / 2 + 1;
    end
  endfunction

  task automatic check_model();
    bit h, t;
    bit [31:0] g;
    mpred(0, lookup_pc, h, t, g);
    chk("A.pred_hit", a_hit, h);
    chk("A.pred_taken", a_tk, t);
    chk("A.pred_target", a_tg, g);
    chk("A.mispredict", a_mp, exp_misp());
    chk("A.perf_branches", a_pb, m_pb[0]);
    chk("A.perf_mispredicts", a_pm, m_pm[0]);
    mpred(1, lookup_pc, h, t, g);
    chk("B.pred_hit", b_hit, h);
    chk("B.pred_taken", b_tk, t);
    chk("B.pred_target", b_tg, g);
    chk("B.mispredict", b_mp, exp_misp());
    chk("B.perf_branches", b_pb, m_pb[1]);
    chk("B.perf_mispredicts", b_pm, m_pm[1]);
  endtask

  task automatic tick();
    @(posedge CLK);
    mupdate(0);
    mupdate(1);
    #1;
  endtask

  task automatic idle(input bit [31:0] lk);
    rst = N; upd_en = N; upd_pc = '0; upd_taken = N; upd_target = '0;
    upd_pred_taken = N; upd_pred_target = '0; flush = N; lookup_pc = lk;
  endtask

  typedef struct {
    bit rst, en; bit [31:0] pc; bit tk; bit [31:0] tg; bit ptk; bit [31:0] ptg;
    bit fl; bit [31:0] lk;
    bit e_hit, e_tk; bit [31:0] e_tg; bit e_mp; int unsigned e_pb, e_pm;
  } vec_t;

  function automatic vec_t v(bit r, bit en, bit [31:0] pc, bit tk, bit [31:0] tg, bit ptk,
                             bit [31:0] ptg, bit fl, bit [31:0] lk, bit eh, bit et,
                             bit [31:0] eg, bit em, int unsigned pb, int unsigned pm);
    v = '{r, en, pc, tk, tg, ptk, ptg, fl, lk, eh, et, eg, em, pb, pm};
  endfunction

  vec_t tbl[24];

  initial begin
    // Expected values for the 16-entry / 2-bit instance, observed before each edge.
    tbl[0]  = v(Y,N,32'h0,  N,32'h0,  N,32'h0,  N,32'h40,       N,N,32'h44, N, 0,0);
    tbl[1]  = v(N,N,32'h0,  N,32'h0,  N,32'h0,  N,32'h40,       N,N,32'h44, N, 0,0);
    tbl[2]  = v(N,Y,32'h40, Y,32'h100,N,32'h0,  N,32'h40,       N,N,32'h44, Y, 0,0);
    tbl[3]  = v(N,N,32'h0,  N,32'h0,  N,32'h0,  N,32'h40,       Y,Y,32'h100,N, 1,1);
    tbl[4]  = v(N,Y,32'h40, N,32'h0,  Y,32'h100,N,32'h40,       Y,Y,32'h100,Y, 1,1);
    tbl[5]  = v(N,Y,32'h40, Y,32'h100,N,32'h0,  N,32'h40,       Y,N,32'h44, Y, 2,2);
    tbl[6]  = v(N,Y,32'h40, Y,32'h100,Y,32'h100,N,32'h40,       Y,Y,32'h100,N, 3,3);
    tbl[7]  = v(N,Y,32'h40, Y,32'h100,Y,32'h100,N,32'h40,       Y,Y,32'h100,N, 4,3);
    tbl[8]  = v(N,Y,32'h40, Y,32'h100,Y,32'h100,N,32'h40,       Y,Y,32'h100,N, 5,3);
    tbl[9]  = v(N,Y,32'h40, N,32'h0,  Y,32'h100,N,32'h40,       Y,Y,32'h100,Y, 6,3);
    tbl[10] = v(N,N,32'h0,  N,32'h0,  N,32'h0,  N,32'h40,       Y,Y,32'h100,N, 7,4);
    tbl[11] = v(N,Y,32'h440,Y,32'h200,N,32'h0,  N,32'h440,      N,N,32'h444,Y, 7,4);
    tbl[12] = v(N,N,32'h0,  N,32'h0,  N,32'h0,  N,32'h40,       N,N,32'h44, N, 8,5);
    tbl[13] = v(N,Y,32'h840,N,32'h0,  N,32'h0,  N,32'h440,      Y,Y,32'h200,N, 8,5);
    tbl[14] = v(N,N,32'h0,  N,32'h0,  N,32'h0,  N,32'h442,      Y,Y,32'h200,N, 9,5);
    tbl[15] = v(N,N,32'h0,  N,32'h0,  N,32'h0,  N,32'h840,      N,N,32'h844,N, 9,5);
    tbl[16] = v(N,Y,32'h80, Y,32'h300,Y,32'h300,Y,32'h440,      Y,Y,32'h200,N, 9,5);
    tbl[17] = v(N,N,32'h0,  N,32'h0,  N,32'h0,  N,32'h80,       N,N,32'h84, N,10,5);
    tbl[18] = v(N,N,32'h0,  N,32'h0,  N,32'h0,  N,32'h440,      N,N,32'h444,N,10,5);
    tbl[19] = v(N,Y,32'h80, Y,32'h400,Y,32'h300,N,32'h80,       N,N,32'h84, Y,10,5);
    tbl[20] = v(N,N,32'h0,  N,32'h0,  N,32'h0,  N,32'h80,       Y,Y,32'h400,N,11,6);
    tbl[21] = v(Y,Y,32'h80, Y,32'h500,N,32'h0,  N,32'h80,       N,N,32'h84, Y,11,6);
    tbl[22] = v(N,N,32'h0,  N,32'h0,  N,32'h0,  N,32'h80,       N,N,32'h84, N, 0,0);
    tbl[23] = v(N,N,32'h0,  N,32'h0,  N,32'h0,  N,32'hFFFF_FFFC,N,N,32'h0,  N, 0,0);

    idle(32'h0);
    rst = Y;
    #2;
    tick();

    foreach (tbl[r]) begin
      rst = tbl[r].rst; upd_en = tbl[r].en; upd_pc = tbl[r].pc; upd_taken = tbl[r].tk;
      upd_target = tbl[r].tg; upd_pred_taken = tbl[r].ptk; upd_pred_target = tbl[r].ptg;
      flush = tbl[r].fl; lookup_pc = tbl[r].lk;
      #2;
      chk($sformatf("vec%0d.pred_hit", r), a_hit, tbl[r].e_hit);
      chk($sformatf("vec%0d.pred_taken", r), a_tk, tbl[r].e_tk);
      chk($sformatf("vec%0d.pred_target", r), a_tg, tbl[r].e_tg);
      chk($sformatf("vec%0d.mispredict", r), a_mp, tbl[r].e_mp);
      chk($sformatf("vec%0d.perf_branches", r), a_pb, tbl[r].e_pb);
      chk($sformatf("vec%0d.perf_mispredicts", r), a_pm, tbl[r].e_pm);
      check_model();
      tick();
    end

    // 20 mispredicting updates: the 4-bit counters must pin at 15.
    for (int i = 0; i < 20; i++) begin
      idle(32'h0);
      upd_en = Y; upd_pc = 32'h1000 + 32'(i) * 4; upd_taken = Y; upd_target = 32'h2000;
      #2;
      check_model();
      tick();
    end
    idle(32'h0);
    #2;
    chk("sat.B.perf_branches", b_pb, 64'd15);
    chk("sat.B.perf_mispredicts", b_pm, 64'd15);
    chk("sat.A.perf_branches", a_pb, 64'd20);
    chk("sat.A.perf_mispredicts", a_pm, 64'd20);
    tick();

    for (int n = 0; n < 3000; n++) begin
      bit h, t;
      bit [31:0] g;
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      upd_en    = ($urandom_range(0, 9) < 6);
      upd_pc    = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 31)) << 2)
                  | 32'($urandom_range(0, 3));
      upd_taken = $urandom_range(0, 1) == 1;
      upd_target = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 1) == 1) begin
        mpred(0, upd_pc, h, t, g);
        upd_pred_taken = t; upd_pred_target = g;
      end else begin
        upd_pred_taken = $urandom_range(0, 1) == 1;
        upd_pred_target = 32'($urandom_range(0, 15)) << 2;
      end
      if ($urandom_range(0, 7) == 0)
        lookup_pc = $urandom;
      else
        lookup_pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 31)) << 2)
                    | 32'($urandom_range(0, 3));
      #2;
      check_model();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
